led_matrix_scanner: RTL and testbench

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

---
 rtl/led_pkg.sv | 15 +
 rtl/scan_timer.sv | 28 ++
 rtl/led_matrix_scanner.sv | 155 +++++++++++++++
 tb/tb_led_matrix_scanner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and geometry for the LED matrix scanner.
package led_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        BLANK = 2'd3
    } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter used for the row dwell and blanking intervals.
// zero_o is high whenever the counter has run out.
module scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Reload on strobe, otherwise count down and hold at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scanner for an 8x8 bi-colour LED matrix.
//
// state | meaning
// IDLE  | no row driven, waiting for enable
// LOAD  | one cycle: snapshot pixel arrays into shadow registers
// DRIVE | current row lit for DWELL_CYCLES
// BLANK | all rows off for BLANK_CYCLES before the next row
//
// The timer is loaded with (interval - 1) on the edge that enters a timed
// state, so the state exits on the cycle the timer reads zero.
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [ROWS-1:0][COLS-1:0]  redarray,
    input  logic [ROWS-1:0][COLS-1:0]  greenarray,
    output logic [ROWS-1:0]            row_sel,
    output logic [COLS-1:0]            red_col,
    output logic [COLS-1:0]            green_col,
    output logic [ROW_W-1:0]           cur_row,
    output logic                       frame_done,
    output logic                       busy
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    scan_state_t               state_q;
    logic [ROWS-1:0][COLS-1:0] shadow_red_q;
    logic [ROWS-1:0][COLS-1:0] shadow_green_q;
    logic [ROWS-1:0]           row_sel_q;
    logic [COLS-1:0]           red_col_q;
    logic [COLS-1:0]           green_col_q;
    logic [ROW_W-1:0]          cur_row_q;
    logic                      frame_done_q;
    logic                      busy_q;

    logic                      tmr_load_d;
    logic [CNT_W-1:0]          tmr_val_d;
    logic                      tmr_zero;
    logic [ROW_W-1:0]          next_row_d;

    assign next_row_d = cur_row_q + ROW_W'(1);

    scan_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .zero_o     (tmr_zero)
    );

    // Timer reload on every entry into DRIVE or BLANK.
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = DWELL_LD;
        case (state_q)
            LOAD:  tmr_load_d = 1'b1;
            DRIVE: begin
                if (tmr_zero) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = BLANK_LD;
                end
            end
            BLANK: tmr_load_d = tmr_zero && (cur_row_q != LAST_ROW);
            default: tmr_load_d = 1'b0;
        endcase
    end

    // Scan FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            shadow_red_q   <= '0;
            shadow_green_q <= '0;
            row_sel_q      <= '0;
            red_col_q      <= '0;
            green_col_q    <= '0;
            cur_row_q      <= '0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        cur_row_q <= '0;
                    end
                end
                LOAD: begin
                    shadow_red_q   <= redarray;
                    shadow_green_q <= greenarray;
                    cur_row_q      <= '0;
                    row_sel_q      <= ROWS'(1);
                    red_col_q      <= redarray[0];
                    green_col_q    <= greenarray[0];
                    state_q        <= DRIVE;
                end
                DRIVE: begin
                    if (tmr_zero) begin
                        row_sel_q   <= '0;
                        red_col_q   <= '0;
                        green_col_q <= '0;
                        state_q     <= BLANK;
                    end
                end
                BLANK: begin
                    if (tmr_zero) begin
                        if (cur_row_q != LAST_ROW) begin
                            cur_row_q   <= next_row_d;
                            row_sel_q   <= ROWS'(1) << next_row_d;
                            red_col_q   <= shadow_red_q[next_row_d];
                            green_col_q <= shadow_green_q[next_row_d];
                            state_q     <= DRIVE;
                        end else begin
                            frame_done_q <= 1'b1;
                            cur_row_q    <= '0;
                            if (enable) begin
                                state_q <= LOAD;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign row_sel    = row_sel_q;
    assign red_col    = red_col_q;
    assign green_col  = green_col_q;
    assign cur_row    = cur_row_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DWELL=4, BLANK=2.
module tb_led_matrix_scanner;

    localparam int D  = 4;
    localparam int B  = 2;
    localparam int FP = 1 + 8 * (D + B);
    localparam int NCAP = 150;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [7:0][7:0]      redarray;
    logic [7:0][7:0]      greenarray;
    logic [7:0]           row_sel;
    logic [7:0]           red_col;
    logic [7:0]           green_col;
    logic [2:0]           cur_row;
    logic                 frame_done;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .redarray   (redarray),
        .greenarray (greenarray),
        .row_sel    (row_sel),
        .red_col    (red_col),
        .green_col  (green_col),
        .cur_row    (cur_row),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct {
        int         cyc;
        logic [7:0] rs;
        logic [7:0] rc;
        logic [7:0] gc;
        logic [2:0] row;
        logic       fd;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] cap[NCAP];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {3'b000, row_sel, red_col, green_col, cur_row, frame_done, busy};
    endfunction

    function automatic logic [31:0] vpack(input vec_t v);
        return {3'b000, v.rs, v.rc, v.gc, v.row, v.fd, v.bsy};
    endfunction

    function automatic vec_t mkvec(input int c, input logic [7:0] rs, input logic [7:0] rc,
                                   input logic [7:0] gc, input logic [2:0] row,
                                   input logic fd, input logic bsy);
        vec_t v;
        v.cyc = c; v.rs = rs; v.rc = rc; v.gc = gc; v.row = row; v.fd = fd; v.bsy = bsy;
        return v;
    endfunction

    task automatic wait_row(input int r, output bit ok);
        logic [7:0] one;
        one = 8'h01;
        ok  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (row_sel == (one << r)) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("reach_row%0d", r), {31'd0, ok}, 32'd1);
    endtask

    task automatic watch_frame(input logic [7:0] exp_g, input string tag,
                               output logic [7:0] mask, output bit seen_fd);
        mask    = '0;
        seen_fd = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (row_sel != 8'h00) begin
                chk($sformatf("%s_green_row%0d", tag, cur_row), {24'd0, green_col}, {24'd0, exp_g});
                mask = mask | row_sel;
            end
            if (frame_done) begin
                seen_fd = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         ok;
        bit         fd_seen;
        logic [7:0] mask;
        logic [7:0] one;
        vec_t       v0;

        one        = 8'h01;
        reset      = 1'b1;
        enable     = 1'b0;
        redarray   = '0;
        greenarray = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_cyc%0d", i), outs(), 32'd0);
        end

        // Expected first-frame timeline, cycle 0 = LOAD.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < D; k++)
                vecs.push_back(mkvec(1 + (D + B) * r + k, one << r, one << r, 8'h00, 3'(r), 1'b0, 1'b1));
            for (int k = 0; k < B; k++)
                vecs.push_back(mkvec(1 + (D + B) * r + D + k, 8'h00, 8'h00, 8'h00, 3'(r), 1'b0, 1'b1));
        end
        vecs.push_back(mkvec(FP, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1));

        for (int r = 0; r < 8; r++) redarray[r] = one << r;
        enable = 1'b1;
        for (int i = 0; i < NCAP; i++) begin
            @(negedge clk);
            cap[i] = outs();
        end

        v0 = mkvec(0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        chk("frame0_load", cap[0], vpack(v0));
        for (int f = 0; f < 3; f++) begin
            foreach (vecs[j]) begin
                chk($sformatf("frame%0d_cyc%0d", f, vecs[j].cyc), cap[f * FP + vecs[j].cyc], vpack(vecs[j]));
            end
        end
        for (int i = 0; i < NCAP; i++) begin
            logic [7:0] rs;
            rs = cap[i][28:21];
            chk($sformatf("onehot_cyc%0d", i), {31'd0, ($countones(rs) <= 1)}, 32'd1);
            if (rs == 8'h00)
                chk($sformatf("cols_off_cyc%0d", i), {16'd0, cap[i][20:5]}, 32'd0);
        end

        // Green change mid-frame must not tear the frame in progress.
        wait_row(3, ok);
        for (int r = 0; r < 8; r++) greenarray[r] = 8'hFF;
        watch_frame(8'h00, "green_old", mask, fd_seen);
        chk("green_old_fd", {31'd0, fd_seen}, 32'd1);
        chk("green_old_rows", {27'd0, mask[7:3]}, 32'h1F);
        watch_frame(8'hFF, "green_new", mask, fd_seen);
        chk("green_new_fd", {31'd0, fd_seen}, 32'd1);
        chk("green_new_rows", {24'd0, mask}, 32'hFF);

        // Dropping enable mid-frame finishes the frame, then idles.
        wait_row(2, ok);
        enable = 1'b0;
        watch_frame(8'hFF, "drop", mask, fd_seen);
        chk("drop_fd", {31'd0, fd_seen}, 32'd1);
        chk("drop_rows", {26'd0, mask[7:2]}, 32'h3F);
        chk("drop_busy_at_fd", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("drop_idle_cyc%0d", i), outs(), 32'd0);
        end

        // Reset during row 5 drive blanks at once, then restarts at row 0.
        enable = 1'b1;
        wait_row(5, ok);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_drive", outs(), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold_cyc%0d", i), outs(), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("restart_load", outs(), vpack(mkvec(0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1)));
        @(negedge clk);
        chk("restart_row0", outs(), vpack(mkvec(1, 8'h01, 8'h01, 8'hFF, 3'd0, 1'b0, 1'b1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
